grad_syncgen: RTL and testbench

Pixel-clock-domain video source for the HDMI output path: generates 640x480 @ 60 Hz VGA timing (HS/VS/DE) and a four-band horizontal gradation test pattern, with optional per-frame horizontal scrolling. Its outputs drive the RGB/sync/DE inputs of the DVI/TMDS encoder directly. The pixel clock (25.175 MHz nominal, 25–30 MHz range) is produced outside this block.

---
 rtl/grad_syncgen.sv | 123 ++++++++++++
 tb/tb_grad_syncgen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/grad_syncgen.sv
// grad_syncgen: VGA-style timing generator with a four-band horizontal gradation
// test pattern and optional one-pixel-per-frame horizontal scroll.
module grad_syncgen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SCROLL   = 0
) (
   input  logic       CLK,
   input  logic       RST,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_DE,
   output logic       FRAME
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_MAX   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  OFF_MAX = 10'(H_ACTIVE - 1);
   localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);

   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic [9:0]  offset_q, offset_d;
   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, frame_q, frame_d;
   logic        h_last, v_last;
   logic [10:0] sum, x;
   logic [7:0]  level;

   always_comb begin
      h_last   = (hcnt_q == H_MAX);
      v_last   = (vcnt_q == V_MAX);
      hcnt_d   = h_last ? '0 : hcnt_q + 10'd1;
      vcnt_d   = vcnt_q;
      offset_d = offset_q;
      if (h_last) begin
         vcnt_d = v_last ? '0 : vcnt_q + 10'd1;
      end
      // Offset only moves at the frame wrap so a frame is never torn mid-scan.
      if (SCROLL != 0 && h_last && v_last) begin
         offset_d = (offset_q == OFF_MAX) ? '0 : offset_q + 10'd1;
      end
   end

   always_comb begin
      sum     = {1'b0, hcnt_q} + {1'b0, offset_q};
      x       = (sum >= H_ACT11) ? sum - H_ACT11 : sum;
      level   = (x < 11'd512) ? x[8:1] : 8'hFF;
      de_d    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hs_d    = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d    = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
      frame_d = (hcnt_q == '0) && (vcnt_q == '0);
      r_d     = '0;
      g_d     = '0;
      b_d     = '0;
      if (de_d) begin
         if (vcnt_q < 10'd120) begin
            r_d = level;
         end else if (vcnt_q < 10'd240) begin
            g_d = level;
         end else if (vcnt_q < 10'd360) begin
            b_d = level;
         end else begin
            r_d = level;
            g_d = level;
            b_d = level;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         offset_q <= '0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         de_q     <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         hcnt_q   <= hcnt_d;
         vcnt_q   <= vcnt_d;
         offset_q <= offset_d;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         de_q     <= de_d;
         frame_q  <= frame_d;
      end
   end

   assign VGA_R  = r_q;
   assign VGA_G  = g_q;
   assign VGA_B  = b_q;
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;
   assign VGA_DE = de_q;
   assign FRAME  = frame_q;

endmodule

// File: tb/tb_grad_syncgen.sv
// Bench for grad_syncgen: three parameterisations share clock and reset; a frame-level
// pixel model feeds per-instance queues that a negedge monitor drains and compares.
module tb_grad_syncgen;

   localparam int N = 3;
   // inst0: wide lines, short frames (saturation, scroll); inst1: narrow lines, full
   // height (bands, vertical timing, offset wrap); inst2: default 640x480, static.
   localparam int P_HA [N] = '{520, 6, 640};
   localparam int P_HF [N] = '{4, 1, 16};
   localparam int P_HS [N] = '{8, 2, 96};
   localparam int P_HB [N] = '{4, 1, 48};
   localparam int P_VA [N] = '{3, 480, 480};
   localparam int P_VF [N] = '{1, 10, 10};
   localparam int P_VS [N] = '{1, 2, 2};
   localparam int P_VB [N] = '{1, 33, 33};
   localparam int P_SC [N] = '{1, 1, 0};

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fr;
   } pix_t;

   localparam pix_t RST_PIX = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: 1'b1, vs: 1'b1, de: 1'b0, fr: 1'b0};

   typedef struct {
      int         k;
      int         t;
      logic [23:0] rgb;
   } dir_t;

   dir_t dir_tab [14] = '{
      '{2, 0,     24'h000000},
      '{2, 255,   24'h7F0000},
      '{2, 511,   24'hFF0000},
      '{2, 600,   24'hFF0000},
      '{0, 511,   24'hFF0000},
      '{0, 3216,  24'h000000},
      '{0, 3218,  24'h010000},
      '{1, 1303,  24'h000100},
      '{1, 2503,  24'h000001},
      '{1, 4005,  24'h020202},
      '{1, 5250,  24'h000000},
      '{1, 5251,  24'h010000},
      '{1, 26254, 24'h010000},
      '{1, 31504, 24'h020000}
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] r_w [N];
   logic [7:0] g_w [N];
   logic [7:0] b_w [N];
   logic       hs_w [N];
   logic       vs_w [N];
   logic       de_w [N];
   logic       fr_w [N];
   pix_t       act [N];

   for (genvar k = 0; k < N; k++) begin : g_dut
      grad_syncgen #(
         .H_ACTIVE(P_HA[k]), .H_FP(P_HF[k]), .H_SYNC(P_HS[k]), .H_BP(P_HB[k]),
         .V_ACTIVE(P_VA[k]), .V_FP(P_VF[k]), .V_SYNC(P_VS[k]), .V_BP(P_VB[k]),
         .SCROLL(P_SC[k])
      ) u_dut (
         .CLK(clk), .RST(rst),
         .VGA_R(r_w[k]), .VGA_G(g_w[k]), .VGA_B(b_w[k]),
         .VGA_HS(hs_w[k]), .VGA_VS(vs_w[k]), .VGA_DE(de_w[k]), .FRAME(fr_w[k])
      );
      assign act[k] = {r_w[k], g_w[k], b_w[k], hs_w[k], vs_w[k], de_w[k], fr_w[k]};
   end

   int total = 0;
   int bad   = 0;

   function automatic int frame_len(input int k);
      return (P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k]) * (P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k]);
   endfunction

   // Pixel t (clocks since reset release) decomposed into frame, line and column.
   function automatic pix_t model(input int k, input int t);
      int   ht, f, p, h, v, off, x, lvl;
      pix_t e;
      ht  = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
      f   = t / frame_len(k);
      p   = t % frame_len(k);
      v   = p / ht;
      h   = p % ht;
      off = (P_SC[k] != 0) ? f % P_HA[k] : 0;
      x   = (h + off) % P_HA[k];
      lvl = (x < 512) ? x / 2 : 255;
      e    = '0;
      e.de = (h < P_HA[k]) && (v < P_VA[k]);
      e.hs = !((h >= P_HA[k] + P_HF[k]) && (h < P_HA[k] + P_HF[k] + P_HS[k]));
      e.vs = !((v >= P_VA[k] + P_VF[k]) && (v < P_VA[k] + P_VF[k] + P_VS[k]));
      e.fr = (h == 0) && (v == 0);
      if (e.de) begin
         if (v < 120)      e.r = 8'(lvl);
         else if (v < 240) e.g = 8'(lvl);
         else if (v < 360) e.b = 8'(lvl);
         else begin
            e.r = 8'(lvl);
            e.g = 8'(lvl);
            e.b = 8'(lvl);
         end
      end
      return e;
   endfunction

   pix_t q0 [$];
   pix_t q1 [$];
   pix_t q2 [$];

   function automatic bit pop(input int k, output pix_t e);
      e = RST_PIX;
      case (k)
         0: begin if (q0.size() == 0) return 1'b0; e = q0.pop_front(); end
         1: begin if (q1.size() == 0) return 1'b0; e = q1.pop_front(); end
         default: begin if (q2.size() == 0) return 1'b0; e = q2.pop_front(); end
      endcase
      return 1'b1;
   endfunction

   int t_mon = 0;

   task automatic chk_pix(input string name, input int k, input pix_t got, input pix_t want);
      total++;
      if (got !== want) begin
         bad++;
         if (bad <= 25)
            $display("FAIL %s inst=%0d t=%0d got=%h want=%h", name, k, t_mon, got, want);
      end
   endtask

   task automatic chk_int(input string name, input int k, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         if (bad <= 25)
            $display("FAIL %s inst=%0d t=%0d got=%0d want=%0d", name, k, t_mon, got, want);
      end
   endtask

   // Generator: each active edge is one pixel of stimulus; push what it must show.
   int t_gen = 0;
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            t_gen = 0;
            q0.delete();
            q1.delete();
            q2.delete();
         end else begin
            q0.push_back(model(0, t_gen));
            q1.push_back(model(1, t_gen));
            q2.push_back(model(2, t_gen));
            t_gen++;
         end
      end
   end

   int last_fr [N];
   initial begin : monitor
      pix_t e;
      for (int k = 0; k < N; k++) last_fr[k] = -1;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int k = 0; k < N; k++) begin
               chk_pix("reset_hold", k, act[k], RST_PIX);
               last_fr[k] = -1;
            end
            t_mon = 0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (!pop(k, e)) begin
                  total++;
                  bad++;
                  $display("FAIL sb_empty inst=%0d t=%0d got=no_entry want=entry", k, t_mon);
               end else begin
                  chk_pix("pixel", k, act[k], e);
               end
               if (act[k].fr) begin
                  if (last_fr[k] >= 0)
                     chk_int("frame_period", k, t_mon - last_fr[k], frame_len(k));
                  last_fr[k] = t_mon;
               end
            end
            for (int i = 0; i < 14; i++) begin
               if (dir_tab[i].t == t_mon)
                  chk_int("pattern_point", dir_tab[i].k,
                          int'({act[dir_tab[i].k].r, act[dir_tab[i].k].g, act[dir_tab[i].k].b}),
                          int'(dir_tab[i].rgb));
            end
            t_mon++;
         end
      end
   end

   initial begin
      rst = 1'b1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      repeat (42000) @(posedge clk);
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #3 rst = 1'b1;
         #1;
         for (int k = 0; k < N; k++) chk_pix("rst_async", k, act[k], RST_PIX);
         repeat ($urandom_range(1, 5)) @(negedge clk);
         #2 rst = 1'b0;
         repeat ($urandom_range(2000, 7000)) @(posedge clk);
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
